// File: rtl/seg_pkg.sv
// Shared seven-segment encoding constants (active-low, dp off) and slot indices,
// used by both the display driver and the scan decoder.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int unsigned SLOT_UNITS     = 0;
    localparam int unsigned SLOT_TENS      = 1;
    localparam int unsigned SLOT_HUNDREDS  = 2;
    localparam int unsigned SLOT_THOUSANDS = 3;

    typedef enum logic [1:0] {
        TRK_WAIT  = 2'd0,
        TRK_COUNT = 2'd1,
        TRK_HELD  = 2'd2
    } trk_state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational map from an active-low segment pattern to {legal, digit}.
// Define SEG_SCAN_DECODER_STRICT_DP_EN to treat a lit decimal point as illegal.
module seg_pattern_lookup
    import seg_pkg::*;
(
    input  logic [7:0] pattern_i,
    output logic       legal_o,
    output logic [3:0] digit_o
);

    logic [7:0] pat;

    always_comb begin
`ifdef SEG_SCAN_DECODER_STRICT_DP_EN
        pat = pattern_i;
`else
        // Forcing dp high makes its state invisible to the lookup.
        pat = pattern_i | 8'h80;
`endif
        legal_o = 1'b1;
        digit_o = 4'd0;
        case (pat)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment scan bus; rebuilds
// the displayed value as binary. Optional macro: SEG_SCAN_DECODER_STRICT_DP_EN.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dig,
    input  logic [5:0]  sel,
    output logic [15:0] data,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    logic [7:0]  dig_s1_q, dig_s2_q;
    logic [3:0]  sel_s1_q, sel_s2_q;
    logic [11:0] pair_q;
    logic        unused_sel_hi;

    trk_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        capture;

    logic [3:0]  slot_low;
    logic        slot_ok;
    logic [1:0]  slot_idx;
    logic        changed;

    logic        lk_legal;
    logic [3:0]  lk_digit;

    logic [3:0][3:0] digits_q, digits_d;
    logic [3:0]  mask_q, mask_d;
    logic        ill_q, ill_d;
    logic        launch;
    logic [13:0] bin;
    logic [15:0] data_q, data_d;
    logic        valid_q, err_q;

    assign unused_sel_hi = ^sel[5:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_s1_q <= SEG_BLANK;
            dig_s2_q <= SEG_BLANK;
            sel_s1_q <= '1;
            sel_s2_q <= '1;
            pair_q   <= '1;
        end else begin
            dig_s1_q <= dig;
            dig_s2_q <= dig_s1_q;
            sel_s1_q <= sel[3:0];
            sel_s2_q <= sel_s1_q;
            pair_q   <= {dig_s2_q, sel_s2_q};
        end
    end

    assign changed = ({dig_s2_q, sel_s2_q} != pair_q);

    // A slot is live only when exactly one strobe is low; anything else is blanking.
    always_comb begin
        slot_low = ~sel_s2_q;
        slot_ok  = 1'b0;
        slot_idx = 2'd0;
        case (slot_low)
            4'b0001: begin slot_ok = 1'b1; slot_idx = 2'(SLOT_UNITS);     end
            4'b0010: begin slot_ok = 1'b1; slot_idx = 2'(SLOT_TENS);      end
            4'b0100: begin slot_ok = 1'b1; slot_idx = 2'(SLOT_HUNDREDS);  end
            4'b1000: begin slot_ok = 1'b1; slot_idx = 2'(SLOT_THOUSANDS); end
            default: ;
        endcase
    end

    seg_pattern_lookup u_lookup (
        .pattern_i (dig_s2_q),
        .legal_o   (lk_legal),
        .digit_o   (lk_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TRK_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            TRK_WAIT: begin
                if (slot_ok) begin
                    state_d = TRK_COUNT;
                    cnt_d   = '0;
                end
            end
            TRK_COUNT, TRK_HELD: begin
                if (changed) begin
                    state_d = slot_ok ? TRK_COUNT : TRK_WAIT;
                    cnt_d   = '0;
                end else if (state_q == TRK_COUNT) begin
                    if (cnt_q == SETTLE_M1) begin
                        capture = 1'b1;
                        state_d = TRK_HELD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = TRK_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // A full mask launches conversion and clears itself in the same cycle.
    assign launch = (mask_q == 4'hF);
    assign bin = 14'(digits_q[3]) * 14'd1000 + 14'(digits_q[2]) * 14'd100
               + 14'(digits_q[1]) * 14'd10   + 14'(digits_q[0]);

    always_comb begin
        digits_d = digits_q;
        mask_d   = launch ? 4'h0 : mask_q;
        ill_d    = 1'b0;
        data_d   = launch ? {2'b00, bin} : data_q;
        if (capture) begin
            if (lk_legal) begin
                digits_d[slot_idx] = lk_digit;
                mask_d[slot_idx]   = 1'b1;
            end else begin
                mask_d = 4'h0;
                ill_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            mask_q   <= '0;
            ill_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            mask_q   <= mask_d;
            ill_q    <= ill_d;
            data_q   <= data_d;
            valid_q  <= launch;
            err_q    <= ill_q;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected frames are queued as scans are
// driven and compared against each valid pulse captured by the monitor.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  dig = 8'hFF;
    logic [5:0]  sel = 6'h3F;
    logic [15:0] data;
    logic        valid;
    logic        err;

    seg_scan_decoder #(.SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dig   (dig),
        .sel   (sel),
        .data  (data),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    logic [7:0] enc [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int tests = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    // Monitor-owned state.
    int cyc = 0;
    int obs_wr = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_valid_cyc = 0;
    logic [15:0] obs_mem [64];

    // Bench-owned read pointer.
    int obs_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            obs_mem[obs_wr & 63] <= data;
            obs_wr         <= obs_wr + 1;
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (valid && err) both_cnt <= both_cnt + 1;
    end

    task automatic drive_slot(input logic [7:0] d, input int s, input int dwell);
        dig = d;
        sel = 6'h3F & ~(6'd1 << s);
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        dig = 8'hFF;
        sel = 6'h3F;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input int d3, input int d2, input int d1, input int d0, input int dwell);
        drive_slot(enc[d3], 3, dwell);
        drive_slot(enc[d2], 2, dwell);
        drive_slot(enc[d1], 1, dwell);
        drive_slot(enc[d0], 0, dwell);
    endtask

    task automatic apply_reset();
        dig = 8'hFF;
        sel = 6'h3F;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h want=0000", data); end
        tests++;
        if (valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses got valid=%b err=%b want 0/0", valid, err); end
        @(posedge clk); #1;
        apply_reset();
        tests++;
        if (data !== 16'h0000 || valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL post_reset got data=%h valid=%b err=%b want 0000/0/0", data, valid, err);
        end
    endtask

    task automatic test_scan_1234();
        int v0, e0, lat_cyc;
        logic [15:0] e;
        v0 = valid_cnt; e0 = err_cnt;
        exp_q.push_back(16'h04D2);
        drive_slot(enc[1], 3, 10000);
        drive_slot(enc[2], 2, 10000);
        drive_slot(enc[3], 1, 10000);
        lat_cyc = cyc;
        drive_slot(enc[4], 0, 10000);
        while (obs_rd < obs_wr) begin
            tests++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL scan1234_extra got data=%h want no valid", obs_mem[obs_rd & 63]); end
            else begin
                e = exp_q.pop_front();
                if (obs_mem[obs_rd & 63] !== e) begin errors++; $display("FAIL scan1234_data got=%h want=%h", obs_mem[obs_rd & 63], e); end
            end
            obs_rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scan1234_missing got 0 valid want %0d", exp_q.size()); exp_q.delete(); end
        tests++;
        if (valid_cnt - v0 != 1) begin errors++; $display("FAIL scan1234_valid_count got=%0d want=1", valid_cnt - v0); end
        tests++;
        if (err_cnt != e0) begin errors++; $display("FAIL scan1234_err got=%0d want=0", err_cnt - e0); end
        tests++;
        if (last_valid_cyc != lat_cyc + 4 + SETTLE) begin
            errors++; $display("FAIL scan1234_latency got cycle %0d want %0d", last_valid_cyc, lat_cyc + 4 + SETTLE);
        end
    endtask

    task automatic test_scan_0000_9999();
        logic [15:0] e;
        exp_q.push_back(16'h0000);
        scan(0, 0, 0, 0, 40);
        blank(5);
        exp_q.push_back(16'h270F);
        scan(9, 9, 9, 9, 40);
        blank(5);
        while (obs_rd < obs_wr) begin
            tests++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL extremes_extra got data=%h want no valid", obs_mem[obs_rd & 63]); end
            else begin
                e = exp_q.pop_front();
                if (obs_mem[obs_rd & 63] !== e) begin errors++; $display("FAIL extremes_data got=%h want=%h", obs_mem[obs_rd & 63], e); end
            end
            obs_rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL extremes_missing pending=%0d want 0", exp_q.size()); exp_q.delete(); end
        tests++;
        if (data !== 16'h270F) begin errors++; $display("FAIL extremes_hold got=%h want=270F", data); end
    endtask

    task automatic test_illegal_slot();
        int v0, e0;
        logic [15:0] e;
        apply_reset();
        v0 = valid_cnt; e0 = err_cnt;
        drive_slot(enc[0], 3, 40);
        drive_slot(8'hFF, 2, 40);
        drive_slot(enc[4], 1, 40);
        drive_slot(enc[2], 0, 40);
        blank(5);
        tests++;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL illegal_err_count got=%0d want=1", err_cnt - e0); end
        tests++;
        if (valid_cnt != v0) begin errors++; $display("FAIL illegal_no_valid got=%0d want=0", valid_cnt - v0); end
        exp_q.push_back(16'h002A);
        scan(0, 0, 4, 2, 40);
        blank(5);
        while (obs_rd < obs_wr) begin
            tests++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL illegal_extra got data=%h want no valid", obs_mem[obs_rd & 63]); end
            else begin
                e = exp_q.pop_front();
                if (obs_mem[obs_rd & 63] !== e) begin errors++; $display("FAIL illegal_next_data got=%h want=%h", obs_mem[obs_rd & 63], e); end
            end
            obs_rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL illegal_missing pending=%0d want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_glitch();
        logic [15:0] e;
        apply_reset();
        exp_q.push_back(16'h0005);
        drive_slot(enc[0], 3, 40);
        drive_slot(enc[0], 2, 40);
        drive_slot(enc[0], 1, 40);
        drive_slot(enc[8], 0, 5);
        drive_slot(enc[5], 0, 40);
        blank(5);
        while (obs_rd < obs_wr) begin
            tests++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL glitch_extra got data=%h want no valid", obs_mem[obs_rd & 63]); end
            else begin
                e = exp_q.pop_front();
                if (obs_mem[obs_rd & 63] !== e) begin errors++; $display("FAIL glitch_data got=%h want=%h", obs_mem[obs_rd & 63], e); end
            end
            obs_rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_missing pending=%0d want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_midframe();
        int v0;
        logic [15:0] e;
        exp_q.push_back(16'h0005);
        scan(0, 0, 0, 5, 40);
        blank(5);
        drive_slot(enc[5], 3, 40);
        drive_slot(enc[6], 2, 40);
        tests++;
        if (data !== 16'h0005) begin errors++; $display("FAIL midframe_hold got=%h want=0005", data); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (data !== 16'h0000 || valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL midframe_async got data=%h valid=%b err=%b want 0000/0/0", data, valid, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        blank(5);
        v0 = valid_cnt;
        drive_slot(enc[5], 3, 40);
        drive_slot(enc[6], 2, 40);
        drive_slot(enc[7], 1, 40);
        tests++;
        if (valid_cnt != v0) begin errors++; $display("FAIL midframe_early_valid got=%0d want=0", valid_cnt - v0); end
        exp_q.push_back(16'h162E);
        drive_slot(enc[8], 0, 40);
        blank(5);
        while (obs_rd < obs_wr) begin
            tests++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL midframe_extra got data=%h want no valid", obs_mem[obs_rd & 63]); end
            else begin
                e = exp_q.pop_front();
                if (obs_mem[obs_rd & 63] !== e) begin errors++; $display("FAIL midframe_data got=%h want=%h", obs_mem[obs_rd & 63], e); end
            end
            obs_rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL midframe_missing pending=%0d want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_dp();
        int v0, e0;
        logic [15:0] e;
        apply_reset();
        v0 = valid_cnt; e0 = err_cnt;
`ifndef SEG_SCAN_DECODER_STRICT_DP_EN
        exp_q.push_back(16'h0D05);
`endif
        drive_slot(enc[3], 3, 40);
        drive_slot(enc[3], 2, 40);
        drive_slot(enc[3] & 8'h7F, 1, 40);
        drive_slot(enc[3], 0, 40);
        blank(5);
        while (obs_rd < obs_wr) begin
            tests++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL dp_extra got data=%h want no valid", obs_mem[obs_rd & 63]); end
            else begin
                e = exp_q.pop_front();
                if (obs_mem[obs_rd & 63] !== e) begin errors++; $display("FAIL dp_data got=%h want=%h", obs_mem[obs_rd & 63], e); end
            end
            obs_rd++;
        end
        tests++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL dp_missing pending=%0d want 0", exp_q.size()); exp_q.delete(); end
`ifdef SEG_SCAN_DECODER_STRICT_DP_EN
        tests++;
        if (err_cnt - e0 != 1 || valid_cnt != v0) begin
            errors++; $display("FAIL dp_strict got err=%0d valid=%0d want 1/0", err_cnt - e0, valid_cnt - v0);
        end
`else
        tests++;
        if (err_cnt != e0 || valid_cnt - v0 != 1) begin
            errors++; $display("FAIL dp_masked got err=%0d valid=%0d want 0/1", err_cnt - e0, valid_cnt - v0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_scan_0000_9999();
        test_illegal_slot();
        test_glitch();
        test_reset_midframe();
        test_dp();
        tests++;
        if (both_cnt != 0) begin errors++; $display("FAIL valid_err_overlap got=%0d want=0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
